// File: rtl/rx_iq_packer.sv
// rx_iq_packer
// Packs 12-bit I/Q sample pairs from the AD9361 1T1R receive interface into
// 32-bit words {sext16(Q), sext16(I)}, buffers them in a small
// first-word-fall-through FIFO and presents them as a valid/ready stream with
// frame markers. Samples that arrive while the FIFO is full and not draining
// are dropped, counted and flagged.
//
// Ports:
//   clk       - sample clock (interface output clock)
//   rst_n     - asynchronous active-low reset
//   enable    - capture enable, sampled on clk
//   rx_I/rx_Q - 12-bit two's complement sample pair
//   rx_ce     - one-cycle strobe qualifying rx_I/rx_Q
//   m_tdata   - packed word, {sext16(Q), sext16(I)}
//   m_tvalid  - a word is available
//   m_tready  - consumer accepts the current word
//   m_tlast   - current word is the last sample of its frame
//   level     - FIFO occupancy (0..DEPTH)
//   overflow  - sticky flag, set when a sample is dropped
//   drop_cnt  - saturating count of dropped samples
//   ovf_clr   - synchronous clear of overflow and drop_cnt
module rx_iq_packer #(
  parameter int DEPTH     = 16,
  parameter int FRAME_LEN = 1024,
  localparam int AW       = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          enable,
  input  logic [11:0]   rx_I,
  input  logic [11:0]   rx_Q,
  input  logic          rx_ce,
  output logic [31:0]   m_tdata,
  output logic          m_tvalid,
  input  logic          m_tready,
  output logic          m_tlast,
  output logic [AW:0]   level,
  output logic          overflow,
  output logic [15:0]   drop_cnt,
  input  logic          ovf_clr
);

  localparam int FW = $clog2(FRAME_LEN);

  localparam logic [AW-1:0] PTR_ONE    = AW'(1);
  localparam logic [AW:0]   LEVEL_ONE  = (AW + 1)'(1);
  localparam logic [AW:0]   LEVEL_FULL = (AW + 1)'(DEPTH);
  localparam logic [FW-1:0] FRAME_ONE  = FW'(1);
  localparam logic [FW-1:0] FRAME_LAST = FW'(FRAME_LEN - 1);

  // Each entry carries the frame-end marker in bit 32 above the packed word.
  logic [32:0]   mem_q [DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   level_q, level_d;
  logic [FW-1:0] frame_cnt_q, frame_cnt_d;
  logic          overflow_q, overflow_d;
  logic [15:0]   drop_cnt_q, drop_cnt_d;

  logic          push;
  logic          pop;
  logic          full;
  logic          accept;
  logic          drop;
  logic          frame_end;
  logic [32:0]   wr_word;

  // Handshake decode. A full FIFO still accepts a sample when the head word
  // leaves on the same edge, so the slot it frees is reused without a drop.
  always_comb begin
    push      = enable & rx_ce;
    pop       = (level_q != '0) & m_tready;
    full      = (level_q == LEVEL_FULL);
    accept    = push & (~full | pop);
    drop      = push & ~accept;
    frame_end = (frame_cnt_q == FRAME_LAST);
    wr_word   = {frame_end, {{4{rx_Q[11]}}, rx_Q}, {{4{rx_I[11]}}, rx_I}};
  end

  // Next-state logic for pointers, occupancy, framing and drop accounting.
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    level_d     = level_q;
    frame_cnt_d = frame_cnt_q;
    overflow_d  = overflow_q;
    drop_cnt_d  = drop_cnt_q;

    if (accept) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end

    case ({accept, pop})
      2'b10:   level_d = level_q + LEVEL_ONE;
      2'b01:   level_d = level_q - LEVEL_ONE;
      default: level_d = level_q;
    endcase

    // Only delivered samples count toward a frame; a disabled capture
    // abandons any partial frame.
    if (!enable) begin
      frame_cnt_d = '0;
    end else if (accept) begin
      frame_cnt_d = frame_end ? '0 : frame_cnt_q + FRAME_ONE;
    end

    // A drop in the same cycle as a clear wins: the new drop is the first
    // one counted after the clear.
    if (drop) begin
      overflow_d = 1'b1;
      if (ovf_clr) begin
        drop_cnt_d = 16'd1;
      end else if (drop_cnt_q != 16'hFFFF) begin
        drop_cnt_d = drop_cnt_q + 16'd1;
      end
    end else if (ovf_clr) begin
      overflow_d = 1'b0;
      drop_cnt_d = 16'd0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      frame_cnt_q <= '0;
      overflow_q  <= 1'b0;
      drop_cnt_q  <= 16'd0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      frame_cnt_q <= frame_cnt_d;
      overflow_q  <= overflow_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  // Storage has no reset; stale entries are unreachable once the pointers
  // and level are cleared.
  always_ff @(posedge clk) begin
    if (accept) begin
      mem_q[wr_ptr_q] <= wr_word;
    end
  end

  // The head entry is gated by valid so an empty FIFO (including reset)
  // presents zero data and no last marker. Valid depends only on state.
  always_comb begin
    m_tvalid = (level_q != '0);
    m_tdata  = m_tvalid ? mem_q[rd_ptr_q][31:0] : 32'd0;
    m_tlast  = m_tvalid & mem_q[rd_ptr_q][32];
    level    = level_q;
    overflow = overflow_q;
    drop_cnt = drop_cnt_q;
  end

endmodule
